// File: rtl/sobel_pkg.sv
// Shared constants and pixel type for the Sobel pipeline.
// Used by the window generator and the Sobel core wrapper.
package sobel_pkg;

    localparam int PIX_W          = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int WIN_N          = 9;

    typedef logic [PIX_W-1:0] pix_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: async read, sync write at a single address.
// Reading and writing the same address in one cycle returns the old pixel.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  pix_t          wdata_i,
    output pix_t          rdata_o
);

    pix_t mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood for the Sobel core.
// Two line buffers plus a 3x3 shift array; border windows are suppressed.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_sof,
    input  pix_t in_data,
    output logic out_valid,
    output pix_t p0,
    output pix_t p1,
    output pix_t p2,
    output pix_t p3,
    output pix_t p4,
    output pix_t p5,
    output pix_t p6,
    output pix_t p7,
    output pix_t p8,
    output logic frame_done
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic          valid_q, done_q;
    logic          win_ok, last_px;
    pix_t          win_q [WIN_N];
    pix_t          lb0_rd, lb1_rd;

    // A start-of-frame pixel is position (0,0) whatever the counters say.
    assign col_eff = in_sof ? '0 : col_q;
    assign row_eff = in_sof ? '0 : row_q;

    assign win_ok  = (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
    assign last_px = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

    always_comb begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
        if (col_eff == COL_LAST) begin
            col_d = '0;
            if (row_eff == ROW_LAST) begin
                row_d = '0;
            end else begin
                row_d = row_eff + RW'(1);
            end
        end
    end

    // lb1 holds row-1, lb0 holds row-2; lb0 is refilled from lb1's old pixel.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) lb0 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (col_eff),
        .wdata_i (lb1_rd),
        .rdata_o (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) lb1 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (col_eff),
        .wdata_i (in_data),
        .rdata_o (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            valid_q <= in_valid && win_ok;
            done_q  <= in_valid && last_px;
            if (in_valid) begin
                col_q    <= col_d;
                row_q    <= row_d;
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb0_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb1_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= in_data;
            end
        end
    end

    assign out_valid  = valid_q;
    assign frame_done = done_q;
    assign p0 = win_q[0];
    assign p1 = win_q[1];
    assign p2 = win_q[2];
    assign p3 = win_q[3];
    assign p4 = win_q[4];
    assign p5 = win_q[5];
    assign p6 = win_q[6];
    assign p7 = win_q[7];
    assign p8 = win_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: 4x4 frames with hand-derived windows,
// plus a 7x5 random image checked against a reference array.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int W2 = 7;
    localparam int H2 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    pix_t in_data = '0;

    logic out_valid, frame_done, ov2, fd2;
    pix_t p0, p1, p2, p3, p4, p5, p6, p7, p8;
    pix_t q0, q1, q2, q3, q4, q5, q6, q7, q8;

    int checks = 0;
    int errors = 0;

    pix_t img [W2*H2];

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
        .p5(p5), .p6(p6), .p7(p7), .p8(p8), .frame_done(frame_done)
    );

    sobel_window_gen #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_valid(ov2),
        .p0(q0), .p1(q1), .p2(q2), .p3(q3), .p4(q4),
        .p5(q5), .p6(q6), .p7(q7), .p8(q8), .frame_done(fd2)
    );

    wire [71:0] win  = {p0, p1, p2, p3, p4, p5, p6, p7, p8};
    wire [71:0] win2 = {q0, q1, q2, q3, q4, q5, q6, q7, q8};

    // Expected 4x4 window ending at (r,c) when pixel value = base + raster index.
    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], 8'(base + (r - 2 + dr) * W + (c - 2 + dc))};
        return w;
    endfunction

    function automatic logic [71:0] img_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], img[(r - 2 + dr) * W2 + (c - 2 + dc)]};
        return w;
    endfunction

    task automatic drive(input pix_t d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || win !== 72'd0) begin
            errors++;
            $display("FAIL reset: valid=%b done=%b win=%h, want 0 0 0",
                     out_valid, frame_done, win);
        end
        checks++;
        if (ov2 !== 1'b0 || fd2 !== 1'b0 || win2 !== 72'd0) begin
            errors++;
            $display("FAIL reset2: valid=%b done=%b win=%h, want 0 0 0",
                     ov2, fd2, win2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame_continuous();
        int nwin = 0;
        int ndone = 0;
        for (int i = 0; i < W * H; i++) begin
            int r = i / W;
            int c = i % W;
            logic ev;
            drive(8'(i), i == 0);
            ev = (r >= 2) && (c >= 2);
            nwin += int'(out_valid === 1'b1);
            ndone += int'(frame_done === 1'b1);
            checks++;
            if (out_valid !== ev || (ev && win !== exp_win(0, r, c))) begin
                errors++;
                $display("FAIL cont px%0d: valid=%b win=%h, want valid=%b win=%h",
                         i, out_valid, win, ev, exp_win(0, r, c));
            end
            checks++;
            if (frame_done !== (i == W * H - 1)) begin
                errors++;
                $display("FAIL cont done px%0d: got %b want %b",
                         i, frame_done, i == W * H - 1);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL cont idle: valid=%b done=%b, want 0 0", out_valid, frame_done);
        end
        checks++;
        if (nwin != 4 || ndone != 1) begin
            errors++;
            $display("FAIL cont count: windows=%0d done=%0d, want 4 1", nwin, ndone);
        end
    endtask

    task automatic test_gaps();
        int nwin = 0;
        for (int i = 0; i < W * H; i++) begin
            int r = i / W;
            int c = i % W;
            int gap = int'($urandom_range(0, 3));
            logic ev;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL gap idle px%0d: valid=%b done=%b, want 0 0",
                             i, out_valid, frame_done);
                end
            end
            drive(8'(i), i == 0);
            ev = (r >= 2) && (c >= 2);
            nwin += int'(out_valid === 1'b1);
            checks++;
            if (out_valid !== ev || (ev && win !== exp_win(0, r, c))) begin
                errors++;
                $display("FAIL gap px%0d: valid=%b win=%h, want valid=%b win=%h",
                         i, out_valid, win, ev, exp_win(0, r, c));
            end
            checks++;
            if (frame_done !== (i == W * H - 1)) begin
                errors++;
                $display("FAIL gap done px%0d: got %b want %b",
                         i, frame_done, i == W * H - 1);
            end
        end
        checks++;
        if (nwin != 4) begin
            errors++;
            $display("FAIL gap count: windows=%0d want 4", nwin);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            int base = f * 100;
            for (int i = 0; i < W * H; i++) begin
                int r = i / W;
                int c = i % W;
                logic ev;
                drive(8'(base + i), f == 0 && i == 0);
                ev = (r >= 2) && (c >= 2);
                checks++;
                if (out_valid !== ev || (ev && win !== exp_win(base, r, c))) begin
                    errors++;
                    $display("FAIL b2b f%0d px%0d: valid=%b win=%h, want valid=%b win=%h",
                             f, i, out_valid, win, ev, exp_win(base, r, c));
                end
                checks++;
                if (frame_done !== (i == W * H - 1)) begin
                    errors++;
                    $display("FAIL b2b done f%0d px%0d: got %b want %b",
                             f, i, frame_done, i == W * H - 1);
                end
            end
        end
    endtask

    task automatic test_sof_midframe();
        int nwin = 0;
        for (int i = 0; i < 6; i++) begin
            drive(8'(i), i == 0);
            checks++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL sof partial px%0d: valid=%b done=%b, want 0 0",
                         i, out_valid, frame_done);
            end
        end
        for (int i = 0; i < W * H; i++) begin
            int r = i / W;
            int c = i % W;
            logic ev;
            drive(8'(50 + i), i == 0);
            ev = (r >= 2) && (c >= 2);
            nwin += int'(out_valid === 1'b1);
            checks++;
            if (out_valid !== ev || (ev && win !== exp_win(50, r, c))) begin
                errors++;
                $display("FAIL sof px%0d: valid=%b win=%h, want valid=%b win=%h",
                         i, out_valid, win, ev, exp_win(50, r, c));
            end
            checks++;
            if (frame_done !== (i == W * H - 1)) begin
                errors++;
                $display("FAIL sof done px%0d: got %b want %b",
                         i, frame_done, i == W * H - 1);
            end
        end
        checks++;
        if (nwin != 4) begin
            errors++;
            $display("FAIL sof count: windows=%0d want 4", nwin);
        end
    endtask

    task automatic test_reset_midframe();
        int nwin = 0;
        for (int i = 0; i < 11; i++) begin
            drive(8'(i), i == 0);
        end
        checks++;
        if (out_valid !== 1'b1 || win !== exp_win(0, 2, 2)) begin
            errors++;
            $display("FAIL rstmid pre: valid=%b win=%h, want 1 %h",
                     out_valid, win, exp_win(0, 2, 2));
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0 || win !== 72'd0) begin
                errors++;
                $display("FAIL rstmid hold%0d: valid=%b done=%b win=%h, want 0 0 0",
                         k, out_valid, frame_done, win);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            int r = i / W;
            int c = i % W;
            logic ev;
            drive(8'(200 + i), 1'b0);
            ev = (r >= 2) && (c >= 2);
            nwin += int'(out_valid === 1'b1);
            checks++;
            if (out_valid !== ev || (ev && win !== exp_win(200, r, c))) begin
                errors++;
                $display("FAIL rstmid px%0d: valid=%b win=%h, want valid=%b win=%h",
                         i, out_valid, win, ev, exp_win(200, r, c));
            end
        end
        checks++;
        if (nwin != 4) begin
            errors++;
            $display("FAIL rstmid count: windows=%0d want 4", nwin);
        end
    endtask

    task automatic test_random_image();
        int nwin = 0;
        int ndone = 0;
        for (int i = 0; i < W2 * H2; i++) begin
            img[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < W2 * H2; i++) begin
            int r = i / W2;
            int c = i % W2;
            logic ev;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            drive(img[i], i == 0);
            ev = (r >= 2) && (c >= 2);
            nwin += int'(ov2 === 1'b1);
            ndone += int'(fd2 === 1'b1);
            checks++;
            if (ov2 !== ev || (ev && win2 !== img_win(r, c))) begin
                errors++;
                $display("FAIL rand px%0d: valid=%b win=%h, want valid=%b win=%h",
                         i, ov2, win2, ev, img_win(r, c));
            end
        end
        checks++;
        if (nwin != (W2 - 2) * (H2 - 2) || ndone != 1) begin
            errors++;
            $display("FAIL rand count: windows=%0d done=%0d, want %0d 1",
                     nwin, ndone, (W2 - 2) * (H2 - 2));
        end
    endtask

    initial begin
        test_reset();
        test_frame_continuous();
        test_gaps();
        test_back_to_back();
        test_sof_midframe();
        test_reset_midframe();
        test_random_image();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
